// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - pipeline stall/flush control; optional perf counters under HAZARD_PERF_CNT_EN
module hazard_control_unit #(
    parameter int reg_addr_width = 5,
    parameter int MEM_TIMEOUT    = 16
`ifdef HAZARD_PERF_CNT_EN
    ,
    parameter int CNT_WIDTH      = 32
`endif
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [reg_addr_width-1:0] ID_rs1,
    input  logic [reg_addr_width-1:0] ID_rs2,
    input  logic                      ID_uses_rs1,
    input  logic                      ID_uses_rs2,
    input  logic [reg_addr_width-1:0] EX_rd,
    input  logic                      EX_mem_read,
    input  logic                      EX_branch_taken,
    input  logic                      MEM_mem_req,
    input  logic                      MEM_mem_ready,
    output logic                      pc_stall,
    output logic                      IF_ID_stall,
    output logic                      ID_EX_stall,
    output logic                      EX_MEM_stall,
    output logic                      IF_ID_flush,
    output logic                      ID_EX_flush,
    output logic                      MEM_WB_flush,
    output logic                      mem_timeout_err
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]      perf_stall_cycles,
    output logic [CNT_WIDTH-1:0]      perf_flush_events,
    output logic [CNT_WIDTH-1:0]      perf_load_use
`endif
);

    // MEM_TIMEOUT is expected to be at least 2 so MEM_WAIT is entered before timing out.
    localparam int WCW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        HALT     = 2'b10,
        BAD      = 2'b11
    } state_t;

    state_t         state_q, state_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           err_q, err_d;
    logic           load_use;
    logic           mem_wait;
    logic           freeze;

    assign load_use = EX_mem_read && (EX_rd != '0) &&
                      ((ID_uses_rs1 && (EX_rd == ID_rs1)) ||
                       (ID_uses_rs2 && (EX_rd == ID_rs2)));
    assign mem_wait = MEM_mem_req && !MEM_mem_ready;
    assign mem_timeout_err = err_q;

    // Control state register; reset returns to RUN with a cleared wait counter and error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

    // Next-state and Mealy output decode; outputs are forced quiet while reset is held.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        err_d        = err_q;
        freeze       = 1'b0;
        pc_stall     = 1'b0;
        IF_ID_stall  = 1'b0;
        ID_EX_stall  = 1'b0;
        EX_MEM_stall = 1'b0;
        IF_ID_flush  = 1'b0;
        ID_EX_flush  = 1'b0;
        MEM_WB_flush = 1'b0;
        case (state_q)
            RUN: begin
                if (mem_wait) begin
                    freeze     = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = WCW'(1);
                end else if (EX_branch_taken) begin
                    // The ID instruction is discarded, so any load-use on it is moot.
                    IF_ID_flush = 1'b1;
                    ID_EX_flush = 1'b1;
                end else if (load_use) begin
                    // The bubble placed in EX prevents this from firing again next cycle.
                    pc_stall    = 1'b1;
                    IF_ID_stall = 1'b1;
                    ID_EX_flush = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (MEM_mem_ready) begin
                    // Release cycle: everything moves; hazards are re-evaluated next cycle.
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    freeze  = 1'b1;
                    state_d = HALT;
                    err_d   = 1'b1;
                end else begin
                    freeze     = 1'b1;
                    wait_cnt_d = wait_cnt_q + WCW'(1);
                end
            end
            HALT: begin
                freeze = 1'b1;
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
        if (freeze) begin
            pc_stall     = 1'b1;
            IF_ID_stall  = 1'b1;
            ID_EX_stall  = 1'b1;
            EX_MEM_stall = 1'b1;
            MEM_WB_flush = 1'b1;
        end
        if (reset) begin
            pc_stall     = 1'b0;
            IF_ID_stall  = 1'b0;
            ID_EX_stall  = 1'b0;
            EX_MEM_stall = 1'b0;
            IF_ID_flush  = 1'b0;
            ID_EX_flush  = 1'b0;
            MEM_WB_flush = 1'b0;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_WIDTH-1:0] lu_cnt_q, lu_cnt_d;
    logic                 lu_event;

    // Only a load-use stall raises pc_stall without also freezing EX/MEM.
    assign lu_event = pc_stall && !EX_MEM_stall;

    // Saturating event counters; IF_ID_flush is raised only by a taken branch.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        lu_cnt_d    = lu_cnt_q;
        if (pc_stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        if (IF_ID_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
        if (lu_event && (lu_cnt_q != '1)) lu_cnt_d = lu_cnt_q + CNT_WIDTH'(1);
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            lu_cnt_q    <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            lu_cnt_q    <= lu_cnt_d;
        end
    end

    assign perf_stall_cycles = stall_cnt_q;
    assign perf_flush_events = flush_cnt_q;
    assign perf_load_use     = lu_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - self-checking bench for hazard_control_unit
module tb_hazard_control_unit;
    localparam int AW  = 5;
    localparam int TMO = 16;
    localparam logic [6:0] QUIET  = 7'b0000000;
    localparam logic [6:0] FREEZE = 7'b1111001;
    localparam logic [6:0] LU     = 7'b1100010;
    localparam logic [6:0] BR     = 7'b0000110;

    logic clk = 1'b0;
    logic reset;
    logic [AW-1:0] ID_rs1, ID_rs2, EX_rd;
    logic ID_uses_rs1, ID_uses_rs2, EX_mem_read, EX_branch_taken, MEM_mem_req, MEM_mem_ready;
    logic pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall;
    logic IF_ID_flush, ID_EX_flush, MEM_WB_flush, mem_timeout_err;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_stall_cycles, perf_flush_events, perf_load_use;
`endif
    logic [6:0] outv;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_control_unit #(.reg_addr_width(AW), .MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2),
        .EX_rd(EX_rd), .EX_mem_read(EX_mem_read), .EX_branch_taken(EX_branch_taken),
        .MEM_mem_req(MEM_mem_req), .MEM_mem_ready(MEM_mem_ready),
        .pc_stall(pc_stall), .IF_ID_stall(IF_ID_stall), .ID_EX_stall(ID_EX_stall),
        .EX_MEM_stall(EX_MEM_stall), .IF_ID_flush(IF_ID_flush), .ID_EX_flush(ID_EX_flush),
        .MEM_WB_flush(MEM_WB_flush), .mem_timeout_err(mem_timeout_err)
`ifdef HAZARD_PERF_CNT_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_flush_events(perf_flush_events),
        .perf_load_use(perf_load_use)
`endif
    );

    assign outv = {pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, IF_ID_flush, ID_EX_flush, MEM_WB_flush};

    typedef struct {
        logic [AW-1:0] rs1;
        logic          u1;
        logic [AW-1:0] rs2;
        logic          u2;
        logic [AW-1:0] rd;
        logic          mrd;
        logic          br;
        logic          req;
        logic          rdy;
        logic [6:0]    exp;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int rs1, input bit u1, input int rs2, input bit u2, input int rd,
                                input bit mrd, input bit br, input bit req, input bit rdy, input logic [6:0] exp);
        vec_t v;
        v.rs1 = AW'(rs1); v.u1 = u1; v.rs2 = AW'(rs2); v.u2 = u2; v.rd = AW'(rd);
        v.mrd = mrd; v.br = br; v.req = req; v.rdy = rdy; v.exp = exp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Apply one cycle of inputs at the falling edge; outputs settle 1 time unit later.
    task automatic cyc(input bit rst, input int rs1, input bit u1, input int rs2, input bit u2, input int rd,
                       input bit mrd, input bit br, input bit req, input bit rdy);
        @(negedge clk);
        reset = rst; ID_rs1 = AW'(rs1); ID_uses_rs1 = u1; ID_rs2 = AW'(rs2); ID_uses_rs2 = u2;
        EX_rd = AW'(rd); EX_mem_read = mrd; EX_branch_taken = br; MEM_mem_req = req; MEM_mem_ready = rdy;
        #1;
    endtask

    task automatic quiet(input bit rst);
        cyc(rst, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reference model state: consecutive un-ready freeze cycles, halt and sticky error.
    int wlen;
    bit halted, merr;

    initial begin
        logic [6:0] exp;
        bit lu;
        int stuck;
        logic [AW-1:0] r1, r2, rd;
        bit u1, u2, mrd, br, req, rdy, rst;

        reset = 1'b1;
        ID_rs1 = '0; ID_rs2 = '0; EX_rd = '0;
        ID_uses_rs1 = 0; ID_uses_rs2 = 0; EX_mem_read = 0; EX_branch_taken = 0;
        MEM_mem_req = 0; MEM_mem_ready = 0;
        quiet(1);
        quiet(1);
        quiet(0);
        chk("reset_outputs", 32'(outv), 32'(QUIET));
        chk("reset_err", 32'(mem_timeout_err), 0);

        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, QUIET));
        vecs.push_back(mk(5, 1, 0, 0, 5, 1, 0, 0, 0, LU));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 0, 0, QUIET));
        vecs.push_back(mk(1, 1, 7, 1, 7, 1, 0, 0, 0, LU));
        vecs.push_back(mk(1, 1, 7, 0, 7, 1, 0, 0, 0, QUIET));
        vecs.push_back(mk(5, 1, 0, 0, 5, 0, 0, 0, 0, QUIET));
        vecs.push_back(mk(5, 1, 0, 0, 5, 1, 1, 0, 0, BR));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, FREEZE));
        vecs.push_back(mk(5, 1, 0, 0, 5, 1, 0, 1, 1, LU));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, QUIET));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, FREEZE));
        vecs.push_back(mk(9, 0, 3, 1, 9, 1, 0, 0, 0, QUIET));
        vecs.push_back(mk(31, 0, 31, 1, 31, 1, 0, 0, 0, LU));

        for (int i = 0; i < vecs.size(); i++) begin
            quiet(1);
            cyc(0, vecs[i].rs1, vecs[i].u1, vecs[i].rs2, vecs[i].u2, vecs[i].rd,
                vecs[i].mrd, vecs[i].br, vecs[i].req, vecs[i].rdy);
            chk($sformatf("vec%0d", i), 32'(outv), 32'(vecs[i].exp));
        end

        // Load-use lasts one cycle: the following cycle EX holds a bubble.
        quiet(1);
        cyc(0, 5, 1, 0, 0, 5, 1, 0, 0, 0);
        chk("lu_first", 32'(outv), 32'(LU));
        quiet(0);
        chk("lu_bubble", 32'(outv), 32'(QUIET));

        // Three wait cycles then a release cycle with everything quiet.
        quiet(1);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            chk($sformatf("wait3_freeze%0d", i), 32'(outv), 32'(FREEZE));
        end
        cyc(0, 5, 1, 0, 0, 5, 1, 1, 1, 1);
        chk("wait3_release", 32'(outv), 32'(QUIET));
        cyc(0, 5, 1, 0, 0, 5, 1, 0, 0, 0);
        chk("wait3_after_release_lu", 32'(outv), 32'(LU));

        // Timeout: 16 freeze cycles, then sticky error and a persistent freeze.
        quiet(1);
        for (int i = 0; i < TMO; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            chk($sformatf("tmo_freeze%0d", i), 32'(outv), 32'(FREEZE));
            chk($sformatf("tmo_err_low%0d", i), 32'(mem_timeout_err), 0);
        end
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("tmo_err_set", 32'(mem_timeout_err), 1);
        chk("tmo_halt_freeze", 32'(outv), 32'(FREEZE));
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("tmo_halt_ignores_ready", 32'(outv), 32'(FREEZE));
        quiet(0);
        chk("tmo_halt_quiet_inputs", 32'(outv), 32'(FREEZE));
        quiet(1);
        quiet(0);
        chk("tmo_reset_outputs", 32'(outv), 32'(QUIET));
        chk("tmo_reset_err", 32'(mem_timeout_err), 0);

        // Reset during the second wait cycle.
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        chk("rstwait_freeze", 32'(outv), 32'(FREEZE));
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        quiet(0);
        chk("rstwait_after", 32'(outv), 32'(QUIET));
        cyc(0, 0, 0, 4, 1, 4, 1, 0, 0, 0);
        chk("rstwait_lu", 32'(outv), 32'(LU));
        quiet(0);
        chk("rstwait_lu_bubble", 32'(outv), 32'(QUIET));

`ifdef HAZARD_PERF_CNT_EN
        quiet(1);
        for (int k = 0; k < 2; k++) begin
            cyc(0, 5, 1, 0, 0, 5, 1, 0, 0, 0);
            quiet(0);
        end
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        quiet(0);
        chk("perf_load_use", perf_load_use, 2);
        chk("perf_stall_cycles", perf_stall_cycles, 5);
        chk("perf_flush_events", perf_flush_events, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        quiet(0);
        chk("perf_flush_one", perf_flush_events, 1);
`endif

        // Randomized run against the reference model.
        quiet(1);
        wlen = 0; halted = 0; merr = 0; stuck = 0;
        for (int n = 0; n < 4000; n++) begin
            rst = ($urandom_range(0, 79) == 0);
            r1 = AW'($urandom_range(0, 3)); r2 = AW'($urandom_range(0, 3)); rd = AW'($urandom_range(0, 3));
            u1 = $urandom_range(0, 1); u2 = $urandom_range(0, 1);
            mrd = $urandom_range(0, 1); br = ($urandom_range(0, 4) == 0);
            if (stuck == 0 && $urandom_range(0, 149) == 0) stuck = TMO + 4;
            if (stuck > 0) begin
                rst = 0; req = 1; rdy = 0; stuck--;
            end else begin
                req = ($urandom_range(0, 3) == 0); rdy = ($urandom_range(0, 2) == 0);
            end
            cyc(rst, int'(r1), u1, int'(r2), u2, int'(rd), mrd, br, req, rdy);

            lu = mrd && (rd != 0) && ((u1 && rd == r1) || (u2 && rd == r2));
            if (rst)              exp = QUIET;
            else if (halted)      exp = FREEZE;
            else if (wlen > 0)    exp = rdy ? QUIET : FREEZE;
            else if (req && !rdy) exp = FREEZE;
            else if (br)          exp = BR;
            else if (lu)          exp = LU;
            else                  exp = QUIET;
            chk($sformatf("rand%0d_out", n), 32'(outv), 32'(exp));
            chk($sformatf("rand%0d_err", n), 32'(mem_timeout_err), 32'(merr));

            if (rst) begin
                wlen = 0; halted = 0; merr = 0;
            end else if (!halted) begin
                if (wlen > 0) begin
                    if (rdy) wlen = 0;
                    else begin
                        wlen++;
                        if (wlen == TMO) begin
                            halted = 1; merr = 1; wlen = 0;
                        end
                    end
                end else if (req && !rdy) begin
                    wlen = 1;
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
